// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI mode-0 slave: FSM encodings,
// rx FIFO depth and the default idle byte.
package spi_slave_pkg;

    typedef logic [7:0] spi_byte_t;

    localparam logic [0:0] SPI_SLV_IDLE   = 1'b0;
    localparam logic [0:0] SPI_SLV_ACTIVE = 1'b1;

    localparam int        RX_FIFO_DEPTH     = 4;
    localparam spi_byte_t DEFAULT_IDLE_BYTE = 8'hFF;

    function automatic spi_byte_t shift_in_msb_first(input spi_byte_t cur, input logic bit_in);
        return {cur[6:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin and byte-stream bundle of the SPI slave; the slave modport is the
// design's view, the master modport is the system/SPI-master side.
interface spi_slave_if;
    import spi_slave_pkg::*;

    logic      i_spi_sclk;
    logic      i_spi_ss_n;
    logic      i_spi_mosi;
    logic      o_spi_miso;
    logic      o_spi_miso_oe;
    spi_byte_t o_rx_data;
    logic      o_rx_valid;
    logic      i_rx_ready;
    spi_byte_t i_tx_data;
    logic      i_tx_valid;
    logic      o_tx_ready;
    logic      o_overrun;
    logic      o_busy;

    modport slave (
        input  i_spi_sclk, i_spi_ss_n, i_spi_mosi, i_rx_ready, i_tx_data, i_tx_valid,
        output o_spi_miso, o_spi_miso_oe, o_rx_data, o_rx_valid, o_tx_ready, o_overrun, o_busy
    );

    modport master (
        output i_spi_sclk, i_spi_ss_n, i_spi_mosi, i_rx_ready, i_tx_data, i_tx_valid,
        input  o_spi_miso, o_spi_miso_oe, o_rx_data, o_rx_valid, o_tx_ready, o_overrun, o_busy
    );

endinterface

// File: rtl/spi_slave_sync.sv
// Multi-flop pin synchronizer with registered rise/fall pulses taken from
// the last stage against one extra delay stage.
module spi_slave_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Chain resets low so a select held low through reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled in the system clock domain, MSB-first.
// Define SPI_SLAVE_RX_FIFO_EN to replace the rx output register with a 4-entry FIFO.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int        SYNC_STAGES = 2,
    parameter spi_byte_t IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
    input logic        i_clk,
    input logic        i_reset_n,
    spi_slave_if.slave bus
);

    logic       sclk_level_unused;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       ss_level;
    logic       ss_rise;
    logic       ss_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic       mosi_level;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    spi_byte_t  rx_shift;
    spi_byte_t  tx_shift;
    spi_byte_t  hold_data;
    logic       hold_full;
    logic       ss_armed;
    logic       busy;

    logic       push;
    logic       load;
    logic       accept;
    logic       pop;
    spi_byte_t  rx_byte;

    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .pin     (bus.i_spi_sclk),
        .level   (sclk_level_unused),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .pin     (bus.i_spi_ss_n),
        .level   (ss_level),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.i_spi_mosi};
        end
    end

    assign mosi_level = mosi_chain[SYNC_STAGES-1];
    assign rx_byte    = shift_in_msb_first(rx_shift, mosi_level);
    assign accept     = bus.i_tx_valid && !hold_full;

    always_comb begin
        push = 1'b0;
        load = 1'b0;
        if (state == SPI_SLV_IDLE) begin
            load = ss_fall;
        end else if (!ss_rise && sclk_rise && bit_cnt == 3'd7) begin
            push = 1'b1;
            load = 1'b1;
        end
    end

    // The falling edge right after a byte boundary must not shift: the reloaded bit 7 is already on MISO.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= SPI_SLV_IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            if (state == SPI_SLV_IDLE) begin
                if (ss_fall) begin
                    state   <= SPI_SLV_ACTIVE;
                    bit_cnt <= 3'd0;
                end
            end else if (ss_rise) begin
                state   <= SPI_SLV_IDLE;
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                rx_shift <= rx_byte;
                bit_cnt  <= bit_cnt + 3'd1;
            end else if (sclk_fall && bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (load) begin
                tx_shift <= hold_full ? hold_data : IDLE_BYTE;
            end
        end
    end

    // A load in the same cycle as an accept sees the register still empty, so the new byte stays held.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= bus.i_tx_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ss_armed <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ss_armed <= ss_armed | ss_level;
            busy     <= ss_armed & ~ss_level;
        end
    end

    assign bus.o_spi_miso    = tx_shift[7];
    assign bus.o_spi_miso_oe = busy;
    assign bus.o_busy        = busy;
    assign bus.o_tx_ready    = ~hold_full;

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int               FIFO_AW   = $clog2(RX_FIFO_DEPTH);
    localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(RX_FIFO_DEPTH);

    spi_byte_t          fifo_mem [RX_FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   fifo_count;
    logic               push_ok;
    logic               overrun;

    assign pop     = (fifo_count != '0) && bus.i_rx_ready;
    assign push_ok = push && ((fifo_count != FIFO_FULL) || pop);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= push && !push_ok;
            if (push_ok) begin
                fifo_mem[wr_ptr] <= rx_byte;
                wr_ptr           <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
            end else if (pop && !push_ok) begin
                fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
            end
        end
    end

    assign bus.o_rx_data  = fifo_mem[rd_ptr];
    assign bus.o_rx_valid = (fifo_count != '0);
    assign bus.o_overrun  = overrun;
`else
    spi_byte_t rx_data;
    logic      rx_valid;
    logic      overrun;

    assign pop = rx_valid && bus.i_rx_ready;

    // An unpopped byte wins over a new one; the newcomer is dropped and flagged.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (push) begin
                if (rx_valid && !pop) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_byte;
                    rx_valid <= 1'b1;
                end
            end else if (pop) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign bus.o_rx_data  = rx_data;
    assign bus.o_rx_valid = rx_valid;
    assign bus.o_overrun  = overrun;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as SPI master at f_clk/16 and as the
// system-side producer/consumer; honours SPI_SLAVE_RX_FIFO_EN.
module tb_spi_slave;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   overrun_pulses = 0;
    logic [7:0] rx_q [$];

    spi_slave_if bus ();

    spi_slave dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Record every pop and every overrun cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.o_rx_valid && bus.i_rx_ready) rx_q.push_back(bus.o_rx_data);
            if (bus.o_overrun) overrun_pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master transfer; with race set, i_tx_valid is timed onto the byte-boundary load cycle.
    task automatic spi_xfer(input logic [7:0] mosi, input int nbits, input bit race, output logic [7:0] miso);
        miso = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.i_spi_mosi = mosi[i];
            tick(HALF);
            miso[i] = bus.o_spi_miso;
            bus.i_spi_sclk = 1'b1;
            if (race && i == 0) begin
                tick(3);
                bus.i_tx_data  = 8'h77;
                bus.i_tx_valid = 1'b1;
                tick(1);
                bus.i_tx_valid = 1'b0;
                tick(HALF - 4);
            end else begin
                tick(HALF);
            end
            bus.i_spi_sclk = 1'b0;
        end
    endtask

    task automatic preload_tx(input logic [7:0] data);
        bus.i_tx_data  = data;
        bus.i_tx_valid = 1'b1;
        tick(1);
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] dummy;
        reset_n = 1'b0;
        bus.i_spi_ss_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.i_spi_sclk = ~bus.i_spi_sclk;
            tick(3);
        end
        bus.i_spi_sclk = 1'b0;
        compared++; if (bus.o_spi_miso !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_miso: got %b expected 0", bus.o_spi_miso); end
        compared++; if (bus.o_spi_miso_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_miso_oe: got %b expected 0", bus.o_spi_miso_oe); end
        compared++; if (bus.o_rx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", bus.o_rx_valid); end
        compared++; if (bus.o_rx_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rx_data: got %h expected 00", bus.o_rx_data); end
        compared++; if (bus.o_tx_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", bus.o_tx_ready); end
        compared++; if (bus.o_overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.o_overrun); end
        compared++; if (bus.o_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.o_busy); end
        reset_n = 1'b1;
        tick(10);
        spi_xfer(8'hAA, 8, 1'b0, dummy);
        tick(10);
        compared++; if (bus.o_rx_valid !== 1'b0 || rx_q.size() != 0) begin mismatched++; $display("[TB] FAIL post_reset_no_push: rx_valid %b pops %0d expected 0/0", bus.o_rx_valid, rx_q.size()); end
        compared++; if (bus.o_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_busy: got %b expected 0", bus.o_busy); end
        bus.i_spi_ss_n = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic test_full_duplex();
        logic [7:0] m;
        bus.i_rx_ready = 1'b0;
        rx_q.delete();
        preload_tx(8'hA5);
        compared++; if (bus.o_tx_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL fd_tx_ready_low: got %b expected 0", bus.o_tx_ready); end
        bus.i_spi_ss_n = 1'b0;
        tick(HALF);
        compared++; if (bus.o_busy !== 1'b1 || bus.o_spi_miso_oe !== 1'b1) begin mismatched++; $display("[TB] FAIL fd_busy_oe: got %b/%b expected 1/1", bus.o_busy, bus.o_spi_miso_oe); end
        spi_xfer(8'h3C, 8, 1'b0, m);
        tick(HALF);
        compared++; if (m !== 8'hA5) begin mismatched++; $display("[TB] FAIL fd_miso_byte: got %h expected a5", m); end
        compared++; if (bus.o_rx_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL fd_rx_valid: got %b expected 1", bus.o_rx_valid); end
        compared++; if (bus.o_rx_data !== 8'h3C) begin mismatched++; $display("[TB] FAIL fd_rx_data: got %h expected 3c", bus.o_rx_data); end
        compared++; if (bus.o_tx_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL fd_tx_ready_back: got %b expected 1", bus.o_tx_ready); end
        bus.i_spi_ss_n = 1'b1;
        tick(HALF);
        compared++; if (bus.o_busy !== 1'b0 || bus.o_spi_miso_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL fd_deselect: got %b/%b expected 0/0", bus.o_busy, bus.o_spi_miso_oe); end
        bus.i_rx_ready = 1'b1;
        tick(2);
        compared++; if (bus.o_rx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fd_pop_clears: got %b expected 0", bus.o_rx_valid); end
        compared++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin mismatched++; $display("[TB] FAIL fd_pop_data: got %0d pops expected 1 of 3c", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2;
        bus.i_rx_ready = 1'b1;
        rx_q.delete();
        bus.i_spi_ss_n = 1'b0;
        tick(HALF);
        spi_xfer(8'h01, 8, 1'b0, m1);
        spi_xfer(8'h80, 8, 1'b0, m2);
        tick(HALF);
        bus.i_spi_ss_n = 1'b1;
        tick(HALF);
        compared++; if (m1 !== 8'hFF) begin mismatched++; $display("[TB] FAIL b2b_idle_byte1: got %h expected ff", m1); end
        compared++; if (m2 !== 8'hFF) begin mismatched++; $display("[TB] FAIL b2b_idle_byte2: got %h expected ff", m2); end
        compared++; if (rx_q.size() != 2) begin mismatched++; $display("[TB] FAIL b2b_rx_count: got %0d expected 2", rx_q.size()); end
        else if (rx_q[0] !== 8'h01 || rx_q[1] !== 8'h80) begin mismatched++; $display("[TB] FAIL b2b_rx_stream: got %h %h expected 01 80", rx_q[0], rx_q[1]); end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        bus.i_rx_ready = 1'b1;
        rx_q.delete();
        bus.i_spi_ss_n = 1'b0;
        tick(HALF);
        spi_xfer(8'hF8, 5, 1'b0, m);
        tick(HALF);
        bus.i_spi_ss_n = 1'b1;
        tick(2 * HALF);
        preload_tx(8'h96);
        bus.i_spi_ss_n = 1'b0;
        tick(HALF);
        spi_xfer(8'h55, 8, 1'b0, m);
        tick(HALF);
        bus.i_spi_ss_n = 1'b1;
        tick(HALF);
        compared++; if (m !== 8'h96) begin mismatched++; $display("[TB] FAIL abort_tx_restart: got %h expected 96", m); end
        compared++; if (rx_q.size() != 1) begin mismatched++; $display("[TB] FAIL abort_rx_count: got %0d expected 1", rx_q.size()); end
        else if (rx_q[0] !== 8'h55) begin mismatched++; $display("[TB] FAIL abort_rx_data: got %h expected 55", rx_q[0]); end
    endtask

    task automatic test_overrun();
        logic [7:0] m;
        logic [7:0] sent [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] expq [$];
        int exp_pulses;
`ifdef SPI_SLAVE_RX_FIFO_EN
        expq = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_pulses = 1;
`else
        expq = '{8'h11};
        exp_pulses = 4;
`endif
        bus.i_rx_ready = 1'b0;
        rx_q.delete();
        overrun_pulses = 0;
        bus.i_spi_ss_n = 1'b0;
        tick(HALF);
        for (int i = 0; i < 5; i++) spi_xfer(sent[i], 8, 1'b0, m);
        tick(HALF);
        bus.i_spi_ss_n = 1'b1;
        tick(HALF);
        compared++; if (overrun_pulses != exp_pulses) begin mismatched++; $display("[TB] FAIL ovr_pulses: got %0d expected %0d", overrun_pulses, exp_pulses); end
        compared++; if (bus.o_rx_valid !== 1'b1 || bus.o_rx_data !== 8'h11) begin mismatched++; $display("[TB] FAIL ovr_head: got %b/%h expected 1/11", bus.o_rx_valid, bus.o_rx_data); end
        bus.i_rx_ready = 1'b1;
        tick(8);
        compared++; if (rx_q.size() != expq.size()) begin mismatched++; $display("[TB] FAIL ovr_pop_count: got %0d expected %0d", rx_q.size(), expq.size()); end
        else begin
            for (int i = 0; i < expq.size(); i++) begin
                compared++; if (rx_q[i] !== expq[i]) begin mismatched++; $display("[TB] FAIL ovr_pop_data[%0d]: got %h expected %h", i, rx_q[i], expq[i]); end
            end
        end
        compared++; if (bus.o_rx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ovr_drained: got %b expected 0", bus.o_rx_valid); end
    endtask

    task automatic test_tx_race();
        logic [7:0] m1, m2, m3;
        bus.i_rx_ready = 1'b1;
        compared++; if (bus.o_tx_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL race_start_ready: got %b expected 1", bus.o_tx_ready); end
        bus.i_spi_ss_n = 1'b0;
        tick(HALF);
        spi_xfer(8'h10, 8, 1'b1, m1);
        spi_xfer(8'h20, 8, 1'b0, m2);
        spi_xfer(8'h30, 8, 1'b0, m3);
        tick(HALF);
        bus.i_spi_ss_n = 1'b1;
        tick(HALF);
        compared++; if (m1 !== 8'hFF) begin mismatched++; $display("[TB] FAIL race_byte1: got %h expected ff", m1); end
        compared++; if (m2 !== 8'hFF) begin mismatched++; $display("[TB] FAIL race_byte2: got %h expected ff", m2); end
        compared++; if (m3 !== 8'h77) begin mismatched++; $display("[TB] FAIL race_byte3: got %h expected 77", m3); end
        compared++; if (bus.o_tx_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL race_end_ready: got %b expected 1", bus.o_tx_ready); end
    endtask

    initial begin
        bus.i_spi_sclk = 1'b0;
        bus.i_spi_ss_n = 1'b0;
        bus.i_spi_mosi = 1'b0;
        bus.i_rx_ready = 1'b0;
        bus.i_tx_data  = 8'h00;
        bus.i_tx_valid = 1'b0;
        test_reset();
        test_full_duplex();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_tx_race();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
